// File: rtl/pcs_gen_pkg.sv
// Purpose: shared constants, types and step/packing helpers for the PCS test-pattern generator.
// Latency: none (package only).
// Backpressure: none (package only).
package pcs_gen_pkg;

  localparam int DATA_WIDTH           = 64;
  localparam int HDR_WIDTH            = 2;
  localparam int FRAME_WIDTH          = DATA_WIDTH + HDR_WIDTH;
  localparam int CONTROL_WIDTH        = 8;
  localparam int TRANSCODER_BLOCKS    = 4;
  localparam int TRANSCODER_WIDTH     = 257;
  localparam int TRANSCODER_HDR_WIDTH = 4;
  localparam int SCR_LEN              = 58;

  typedef logic [FRAME_WIDTH-1:0]      frame_t;
  typedef logic [TRANSCODER_WIDTH-1:0] tc_word_t;

  // Sync headers and the only control block type this source emits
  localparam logic [HDR_WIDTH-1:0]     SH_DATA = 2'b01;
  localparam logic [HDR_WIDTH-1:0]     SH_CTRL = 2'b10;
  localparam logic [CONTROL_WIDTH-1:0] BT_IDLE = 8'h1E;

  localparam frame_t CTRL_IDLE_FRAME = {SH_CTRL, BT_IDLE, 56'h0};

  // Sequence seeds; channel 1 payload uses the inverse of PAYLOAD_SEED
  localparam logic [DATA_WIDTH-1:0]    PAYLOAD_SEED = 64'h0123_4567_89AB_CDEF;
  localparam logic [CONTROL_WIDTH-1:0] TYPE_SEED    = 8'hFF;
  localparam logic [SCR_LEN-1:0]       SCR_SEED     = 58'h3FF_FFFF_FFFF_FFFF;

  // Scrambler x^58 + x^39 + 1: state bit 0 is the newest output bit
  localparam int SCR_TAP_LO = 38;
  localparam int SCR_TAP_HI = 57;

  // Payload LFSR x^64+x^63+x^61+x^60+1, shifting left with feedback into bit 0
  function automatic logic [DATA_WIDTH-1:0] payload_lfsr_next(input logic [DATA_WIDTH-1:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // Block-type LFSR x^8+x^6+x^5+x^4+1
  function automatic logic [CONTROL_WIDTH-1:0] type_lfsr_next(input logic [CONTROL_WIDTH-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Random pick: control when the LFSR value mod 100 falls below the percentage
  function automatic logic type_is_ctrl(input logic [CONTROL_WIDTH-1:0] v, input int prob);
    return ((int'({24'd0, v}) % 100) < prob);
  endfunction

  // Block k payload is the LFSR value rotated left by 16*k
  function automatic logic [DATA_WIDTH-1:0] rotl16(input logic [DATA_WIDTH-1:0] p, input logic [1:0] k);
    logic [DATA_WIDTH-1:0] r;
    case (k)
      2'd0:    r = p;
      2'd1:    r = {p[47:0], p[63:48]};
      2'd2:    r = {p[31:0], p[63:32]};
      default: r = {p[15:0], p[63:16]};
    endcase
    return r;
  endfunction

  // First control block of a mixed word drops the upper type nibble; the
  // surviving low nibble leads the packed field, followed by the 56 data bits
  function automatic logic [59:0] compress_ctrl(input logic [DATA_WIDTH-1:0] f);
    return {f[55:0], f[59:56]};
  endfunction

endpackage

// File: rtl/pcs_gen_lane.sv
// Purpose: one PCS channel - four 64b/66b blocks, 256b/257b transcode, x^58+x^39 scramble.
// Latency: frames 1 cycle, transcoded word 2 cycles, scrambled word 3 cycles after i_valid.
// Backpressure: none; i_valid=0 freezes every register in the lane.
module pcs_gen_lane
  import pcs_gen_pkg::*;
#(
  parameter int                    PROB       = 30,
  parameter logic [DATA_WIDTH-1:0] LANE_SEED  = PAYLOAD_SEED
) (
  input  logic                                     clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_valid,
  input  logic                                     i_random,
  input  logic [TRANSCODER_BLOCKS-1:0]             i_data_sel,
  output logic [TRANSCODER_BLOCKS*FRAME_WIDTH-1:0] o_frames,
  output logic [TRANSCODER_WIDTH-1:0]              o_transcoder,
  output logic [TRANSCODER_WIDTH-1:0]              o_scrambler
);

  logic [DATA_WIDTH-1:0]           r_payload_lfsr;
  logic [CONTROL_WIDTH-1:0]        r_type_lfsr;
  frame_t                          r_frame [TRANSCODER_BLOCKS];
  tc_word_t                        r_tc;
  tc_word_t                        r_scr;
  logic [SCR_LEN-1:0]              r_scr_state;

  logic [CONTROL_WIDTH-1:0]        w_type_v [TRANSCODER_BLOCKS];
  logic [TRANSCODER_BLOCKS-1:0]    w_is_data;
  frame_t                          w_frame_nxt [TRANSCODER_BLOCKS];
  logic [TRANSCODER_BLOCKS-1:0]    w_blk_data;
  logic [TRANSCODER_HDR_WIDTH-1:0] w_flags;
  tc_word_t                        w_tc_nxt;
  tc_word_t                        w_scr_nxt;
  logic [SCR_LEN-1:0]              w_scr_state_nxt;

  // Block-type choice: four chained type-LFSR steps, one per block, or the static select
  always_comb begin
    logic [CONTROL_WIDTH-1:0] w_v;
    w_v       = r_type_lfsr;
    w_is_data = '0;
    for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
      w_v          = type_lfsr_next(w_v);
      w_type_v[k]  = w_v;
      w_is_data[k] = i_random ? !type_is_ctrl(w_v, PROB) : i_data_sel[k];
    end
  end

  // Next frames: rotated payload for data blocks, idle control block otherwise
  always_comb begin
    for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
      w_frame_nxt[k] = w_is_data[k] ? {SH_DATA, rotl16(r_payload_lfsr, 2'(k))} : CTRL_IDLE_FRAME;
    end
  end

  // Generator stage: register frames and step both LFSRs once per valid cycle
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_payload_lfsr <= LANE_SEED;
      r_type_lfsr    <= TYPE_SEED;
      for (int k = 0; k < TRANSCODER_BLOCKS; k++) r_frame[k] <= '0;
    end else if (i_valid) begin
      r_payload_lfsr <= payload_lfsr_next(r_payload_lfsr);
      r_type_lfsr    <= w_type_v[TRANSCODER_BLOCKS-1];
      for (int k = 0; k < TRANSCODER_BLOCKS; k++) r_frame[k] <= w_frame_nxt[k];
    end
  end

  // Transcoder: all-data words pass straight through, mixed words carry flags and one compressed type
  always_comb begin
    logic [1:0] w_first;
    logic       w_found;
    w_first    = '0;
    w_found    = 1'b0;
    w_blk_data = '0;
    w_tc_nxt   = '0;
    for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
      w_blk_data[k] = (r_frame[k][FRAME_WIDTH-1:DATA_WIDTH] == SH_DATA);
    end
    for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
      if (!w_blk_data[k] && !w_found) begin
        w_first = 2'(k);
        w_found = 1'b1;
      end
    end
    w_flags = w_blk_data;
    if (&w_blk_data) begin
      w_tc_nxt = {r_frame[3][63:0], r_frame[2][63:0], r_frame[1][63:0], r_frame[0][63:0], 1'b1};
    end else begin
      case (w_first)
        2'd0: w_tc_nxt = {r_frame[3][63:0], r_frame[2][63:0], r_frame[1][63:0],
                          compress_ctrl(r_frame[0][63:0]), w_flags, 1'b0};
        2'd1: w_tc_nxt = {r_frame[3][63:0], r_frame[2][63:0], compress_ctrl(r_frame[1][63:0]),
                          r_frame[0][63:0], w_flags, 1'b0};
        2'd2: w_tc_nxt = {r_frame[3][63:0], compress_ctrl(r_frame[2][63:0]), r_frame[1][63:0],
                          r_frame[0][63:0], w_flags, 1'b0};
        default: w_tc_nxt = {compress_ctrl(r_frame[3][63:0]), r_frame[2][63:0], r_frame[1][63:0],
                             r_frame[0][63:0], w_flags, 1'b0};
      endcase
    end
  end

  // Transcoder stage register
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_tc <= '0;
    end else if (i_valid) begin
      r_tc <= w_tc_nxt;
    end
  end

  // Scrambler: bits 1..256 LSB first through the self-synchronous shift register; header bit passes
  always_comb begin
    logic [SCR_LEN-1:0] w_st;
    w_st         = r_scr_state;
    w_scr_nxt    = '0;
    w_scr_nxt[0] = r_tc[0];
    for (int i = 1; i < TRANSCODER_WIDTH; i++) begin
      w_scr_nxt[i] = r_tc[i] ^ w_st[SCR_TAP_LO] ^ w_st[SCR_TAP_HI];
      w_st         = {w_st[SCR_LEN-2:0], w_scr_nxt[i]};
    end
    w_scr_state_nxt = w_st;
  end

  // Scrambler stage register; state carries over between words
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_scr       <= '0;
      r_scr_state <= SCR_SEED;
    end else if (i_valid) begin
      r_scr       <= w_scr_nxt;
      r_scr_state <= w_scr_state_nxt;
    end
  end

  assign o_frames     = {r_frame[3], r_frame[2], r_frame[1], r_frame[0]};
  assign o_transcoder = r_tc;
  assign o_scrambler  = r_scr;

endmodule

// File: rtl/pcs_generator.sv
// Purpose: two independent PCS test-pattern lanes (frames 0-3 / 4-7) with transcoded and scrambled words.
// Latency: frames 1 cycle, transcoder 2 cycles, scrambler 3 cycles after i_valid.
// Backpressure: none; i_valid=0 holds all state and outputs.
module pcs_generator
  import pcs_gen_pkg::*;
#(
  parameter int PROB = 30
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic         i_random_0,
  input  logic         i_random_1,
  input  logic [3:0]   i_data_sel_0,
  input  logic [3:0]   i_data_sel_1,
  output logic [65:0]  o_frame_0,
  output logic [65:0]  o_frame_1,
  output logic [65:0]  o_frame_2,
  output logic [65:0]  o_frame_3,
  output logic [65:0]  o_frame_4,
  output logic [65:0]  o_frame_5,
  output logic [65:0]  o_frame_6,
  output logic [65:0]  o_frame_7,
  output logic [256:0] o_transcoder_0,
  output logic [256:0] o_transcoder_1,
  output logic [256:0] o_scrambler_0,
  output logic [256:0] o_scrambler_1
);

  logic [TRANSCODER_BLOCKS*FRAME_WIDTH-1:0] w_frames_0;
  logic [TRANSCODER_BLOCKS*FRAME_WIDTH-1:0] w_frames_1;

  pcs_gen_lane #(
    .PROB      (PROB),
    .LANE_SEED (PAYLOAD_SEED)
  ) u_lane_0 (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_random     (i_random_0),
    .i_data_sel   (i_data_sel_0),
    .o_frames     (w_frames_0),
    .o_transcoder (o_transcoder_0),
    .o_scrambler  (o_scrambler_0)
  );

  pcs_gen_lane #(
    .PROB      (PROB),
    .LANE_SEED (~PAYLOAD_SEED)
  ) u_lane_1 (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_random     (i_random_1),
    .i_data_sel   (i_data_sel_1),
    .o_frames     (w_frames_1),
    .o_transcoder (o_transcoder_1),
    .o_scrambler  (o_scrambler_1)
  );

  assign o_frame_0 = w_frames_0[0*FRAME_WIDTH +: FRAME_WIDTH];
  assign o_frame_1 = w_frames_0[1*FRAME_WIDTH +: FRAME_WIDTH];
  assign o_frame_2 = w_frames_0[2*FRAME_WIDTH +: FRAME_WIDTH];
  assign o_frame_3 = w_frames_0[3*FRAME_WIDTH +: FRAME_WIDTH];
  assign o_frame_4 = w_frames_1[0*FRAME_WIDTH +: FRAME_WIDTH];
  assign o_frame_5 = w_frames_1[1*FRAME_WIDTH +: FRAME_WIDTH];
  assign o_frame_6 = w_frames_1[2*FRAME_WIDTH +: FRAME_WIDTH];
  assign o_frame_7 = w_frames_1[3*FRAME_WIDTH +: FRAME_WIDTH];

endmodule

// File: tb/tb_pcs_generator.sv
// Purpose: self-checking bench for pcs_generator with an expected-output scoreboard.
// Latency: expected snapshot per clock, popped by the monitor on the following falling edge.
// Backpressure: exercises i_valid stalls; outputs must hold while stalled.
`timescale 1ns/1ps
module tb_pcs_generator;

  localparam int PROB = 30;

  typedef struct packed {
    logic [7:0][65:0]  frm;
    logic [1:0][256:0] tc;
    logic [1:0][256:0] scr;
  } snap_t;

  logic         clk = 1'b0;
  logic         i_rst_n, i_valid, i_random_0, i_random_1;
  logic [3:0]   i_data_sel_0, i_data_sel_1;
  logic [65:0]  o_frame_0, o_frame_1, o_frame_2, o_frame_3;
  logic [65:0]  o_frame_4, o_frame_5, o_frame_6, o_frame_7;
  logic [256:0] o_transcoder_0, o_transcoder_1, o_scrambler_0, o_scrambler_1;

  always #5 clk = ~clk;

  pcs_generator #(.PROB(PROB)) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .i_random_0     (i_random_0),
    .i_random_1     (i_random_1),
    .i_data_sel_0   (i_data_sel_0),
    .i_data_sel_1   (i_data_sel_1),
    .o_frame_0      (o_frame_0),
    .o_frame_1      (o_frame_1),
    .o_frame_2      (o_frame_2),
    .o_frame_3      (o_frame_3),
    .o_frame_4      (o_frame_4),
    .o_frame_5      (o_frame_5),
    .o_frame_6      (o_frame_6),
    .o_frame_7      (o_frame_7),
    .o_transcoder_0 (o_transcoder_0),
    .o_transcoder_1 (o_transcoder_1),
    .o_scrambler_0  (o_scrambler_0),
    .o_scrambler_1  (o_scrambler_1)
  );

  int checks = 0;
  int errors = 0;

  snap_t exp_cur;
  snap_t sb[$];
  snap_t mon_exp, mon_act;
  logic [1:0][63:0] m_lfsr;
  logic [1:0][7:0]  m_tlfsr;
  logic [1:0][57:0] m_scr;

  task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] lfsr64_nx(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [7:0] lfsr8_nx(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] p, input int sh);
    return (p << sh) | (p >> (64 - sh));
  endfunction

  function automatic logic [256:0] tc_model(input logic [3:0][65:0] fr);
    logic [256:0] t;
    int pos;
    logic first;
    t = '0;
    if (fr[0][65:64] == 2'b01 && fr[1][65:64] == 2'b01 && fr[2][65:64] == 2'b01 && fr[3][65:64] == 2'b01) begin
      t[0] = 1'b1;
      for (int k = 0; k < 4; k++)
        for (int b = 0; b < 64; b++) t[1 + 64*k + b] = fr[k][b];
    end else begin
      for (int k = 0; k < 4; k++) t[1 + k] = (fr[k][65:64] == 2'b01);
      pos = 5;
      first = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (fr[k][65:64] != 2'b01 && first) begin
          for (int b = 0; b < 4; b++)  t[pos + b] = fr[k][56 + b];
          for (int b = 0; b < 56; b++) t[pos + 4 + b] = fr[k][b];
          pos += 60;
          first = 1'b0;
        end else begin
          for (int b = 0; b < 64; b++) t[pos + b] = fr[k][b];
          pos += 64;
        end
      end
    end
    return t;
  endfunction

  function automatic logic [256:0] scr_model(input logic [256:0] d, input logic [57:0] st_in,
                                             output logic [57:0] st_out);
    logic [256:0] o;
    logic [57:0] st;
    st = st_in;
    o = '0;
    o[0] = d[0];
    for (int i = 1; i < 257; i++) begin
      o[i] = d[i] ^ st[38] ^ st[57];
      st = {st[56:0], o[i]};
    end
    st_out = st;
    return o;
  endfunction

  task automatic model_reset();
    exp_cur    = '0;
    m_lfsr[0]  = 64'h0123456789ABCDEF;
    m_lfsr[1]  = 64'hFEDCBA9876543210;
    m_tlfsr[0] = 8'hFF;
    m_tlfsr[1] = 8'hFF;
    m_scr[0]   = {58{1'b1}};
    m_scr[1]   = {58{1'b1}};
  endtask

  task automatic model_update(input logic r0, input logic [3:0] s0, input logic r1, input logic [3:0] s1);
    logic rnd, ctrl;
    logic [3:0] sel;
    logic [7:0] t;
    logic [57:0] st;
    for (int c = 0; c < 2; c++) begin
      rnd = (c == 1) ? r1 : r0;
      sel = (c == 1) ? s1 : s0;
      exp_cur.scr[c] = scr_model(exp_cur.tc[c], m_scr[c], st);
      m_scr[c] = st;
      exp_cur.tc[c] = tc_model(exp_cur.frm[4*c +: 4]);
      t = m_tlfsr[c];
      for (int k = 0; k < 4; k++) begin
        t = lfsr8_nx(t);
        ctrl = rnd ? ((int'(t) % 100) < PROB) : !sel[k];
        exp_cur.frm[4*c + k] = ctrl ? {2'b10, 8'h1E, 56'h0} : {2'b01, rotl(m_lfsr[c], 16*k)};
      end
      m_tlfsr[c] = t;
      m_lfsr[c] = lfsr64_nx(m_lfsr[c]);
    end
  endtask

  // Drive one clock worth of inputs and queue the outputs expected after that edge
  task automatic step(input logic rst_n, input logic v, input logic r0, input logic [3:0] s0,
                      input logic r1, input logic [3:0] s1);
    @(negedge clk);
    #1;
    i_rst_n = rst_n;
    i_valid = v;
    i_random_0 = r0;
    i_data_sel_0 = s0;
    i_random_1 = r1;
    i_data_sel_1 = s1;
    if (!rst_n) model_reset();
    else if (v) model_update(r0, s0, r1, s1);
    sb.push_back(exp_cur);
  endtask

  // Monitor: compare every output against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      mon_act.frm = {o_frame_7, o_frame_6, o_frame_5, o_frame_4, o_frame_3, o_frame_2, o_frame_1, o_frame_0};
      mon_act.tc  = {o_transcoder_1, o_transcoder_0};
      mon_act.scr = {o_scrambler_1, o_scrambler_0};
      for (int i = 0; i < 8; i++) chk($sformatf("frame_%0d", i), mon_act.frm[i], mon_exp.frm[i]);
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("transcoder_%0d", c), mon_act.tc[c], mon_exp.tc[c]);
        chk($sformatf("scrambler_%0d", c), mon_act.scr[c], mon_exp.scr[c]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ctrl_cnt;
    i_rst_n = 1'b0; i_valid = 1'b0; i_random_0 = 1'b0; i_random_1 = 1'b0;
    i_data_sel_0 = 4'h0; i_data_sel_1 = 4'h0;

    // Reset held, then released with valid low: outputs stay zero
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

    // All-data on both channels: first frames are the rotated seeds
    step(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 4'hF);
    @(posedge clk); #1;
    chk("seed_frame0", o_frame_0, {2'b01, 64'h0123456789ABCDEF});
    chk("seed_frame1", o_frame_1, {2'b01, 64'h456789ABCDEF0123});
    chk("seed_frame3", o_frame_3, {2'b01, 64'hCDEF0123456789AB});
    chk("seed_frame4", o_frame_4, {2'b01, 64'hFEDCBA9876543210});
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 4'hF);

    // All-control on channel 0: flags 0, header 0, compressed idle nibble at [8:5]
    repeat (2) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'hF);
    @(posedge clk); #1;
    chk("ctrl_frame2", o_frame_2, {2'b10, 8'h1E, 56'h0});
    chk("ctrl_tc_low", o_transcoder_0[8:0], 9'h1C0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'hF);

    // Mixed-block sweep on channel 0 while channel 1 runs random
    for (int s = 1; s <= 14; s++) begin
      for (int j = 0; j < 10; j++) begin
        step(1'b1, 1'b1, 1'b0, 4'(s), 1'b1, 4'h0);
        if (j == 1) begin
          @(posedge clk); #1;
          chk($sformatf("sweep_hdr_%0d", s), o_transcoder_0[4:0], {4'(s), 1'b0});
        end
      end
    end

    // Stall for 10 cycles, then resume the sequence
    repeat (10) step(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 4'hF);
    repeat (5) step(1'b1, 1'b1, 1'b0, 4'b1010, 1'b0, 4'b0101);

    // Random block types on channel 0: 4080 picks cover sixteen full LFSR periods
    ctrl_cnt = 0;
    for (int n = 0; n < 1020; n++) begin
      step(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'hF);
      @(posedge clk); #1;
      ctrl_cnt += int'(o_frame_0[65:64] == 2'b10) + int'(o_frame_1[65:64] == 2'b10)
                + int'(o_frame_2[65:64] == 2'b10) + int'(o_frame_3[65:64] == 2'b10);
    end
    checks++;
    if (ctrl_cnt * 100 < 25 * 4080 || ctrl_cnt * 100 > 35 * 4080) begin
      errors++;
      $display("FAIL ctrl_fraction: got %0d of 4080 control, required 1020..1428", ctrl_cnt);
    end

    // Reset mid-stream restarts every sequence from its seed
    repeat (2) step(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 4'hF);
    @(posedge clk); #1;
    chk("reseed_frame0", o_frame_0, {2'b01, 64'h0123456789ABCDEF});
    chk("reseed_frame4", o_frame_4, {2'b01, 64'hFEDCBA9876543210});
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 4'b1001);

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 257'(sb.size()), 257'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
